stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Controller for a 4-digit cascaded BCD count chain (0000–9999, one count per tick, e.g. 0.01 s at 100 Hz).
- Owns a prescaler that generates the count-enable tick.
- Sequences the chain through start/pause/resume/clear with a run/pause FSM.
- Provides a lap freeze for the display path; sits between debounced button pulses and the seven-segment mux.

Parameters:
- TICK_DIV, 1000000, clock cycles per count tick (>= 2); 100 MHz / 1e6 = 100 Hz.
- ROLLOVER, 1, 1 = wrap 9999->0000 and set sticky overflow; 0 = saturate at 9999 and stop.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, synchronous, active-high
- i_start_stop  input  1  single-cycle pulse: start/pause/resume
- i_lap  input  1  single-cycle pulse: toggle lap freeze
- i_clear  input  1  single-cycle pulse: return to zero
- o_digits  output  16  displayed BCD value; [3:0] = least-significant digit
- o_count  output  16  live BCD count, never frozen
- o_tick  output  1  one-cycle pulse when the chain is enabled
- o_running  output  1  high in RUN
- o_lap_active  output  1  high while the display is frozen
- o_overflow  output  1  sticky; set on a 9999->0000 wrap

Behaviour:
- Reset (i_rst high at a clock edge):
  - state = IDLE; prescaler = 0.
  - o_count = o_digits = 0x0000; lap latch = 0x0000.
  - o_tick, o_running, o_lap_active, o_overflow all = 0.
  - Reset overrides all other inputs in the same cycle, including mid-count and mid-lap.
- FSM states: IDLE, RUN, PAUSE, SAT.
  - IDLE: start_stop -> RUN, with prescaler cleared.
  - RUN: start_stop -> PAUSE. A terminal tick with ROLLOVER=0 -> SAT.
  - PAUSE: start_stop -> RUN. The prescaler is held, not cleared, so partial tick time is preserved.
  - SAT: start_stop is ignored.
  - clear in IDLE/PAUSE/SAT -> IDLE. It zeroes the count, prescaler and overflow, and releases lap.
  - clear in RUN is ignored.
- Prescaler:
  - Counts only in RUN, over 0..TICK_DIV-1.
  - o_tick is asserted (combinationally) in the cycle the prescaler equals TICK_DIV-1; the prescaler returns to 0 on the next edge.
  - The first tick after start is therefore asserted TICK_DIV cycles after the start pulse cycle.
- Count chain:
  - Digit0 increments on a tick.
  - Digit k increments on a tick when digits 0..k-1 are all 9.
  - A digit at 9 that increments goes to 0.
  - Carries resolve within the same cycle, with no ripple latency.
  - o_count updates on the edge ending the tick cycle.
  - Digits never hold non-BCD values (A–F).
- Terminal count (tick while o_count = 0x9999):
  - ROLLOVER=1: o_count -> 0x0000, o_overflow <= 1, stays RUN.
  - ROLLOVER=0: o_count holds 0x9999, state -> SAT, o_running -> 0, no further ticks.
- Lap:
  - Legal in RUN or PAUSE; ignored in IDLE and SAT.
  - First press: latch o_count as sampled in the press cycle (the pre-increment value if a tick coincides) and set o_lap_active.
  - Second press releases.
  - Counting continues while frozen.
  - o_digits = lap latch when o_lap_active, else o_count.
- Simultaneous events:
  - Priority: clear (when legal) > start_stop > lap. When a legal clear fires, start_stop and lap pulses in that cycle are discarded.
  - start_stop and lap in the same cycle (no clear): both act, e.g. RUN -> PAUSE and lap toggles.
  - A tick and a start_stop (RUN -> PAUSE) in the same cycle: the tick is honoured and the count increments.
- Input assumptions:
  - Inputs are pre-synchronised single-cycle pulses.
  - A held-high input is treated as a pulse every cycle; no edge detection is performed here.
- Outputs are registered, except o_tick and the o_digits select mux.

Test Plan:
- Use TICK_DIV=4 throughout.
1. Reset then start: i_rst 1 cycle, start pulse at cycle 0 -> o_tick at cycles 4, 8, 12; o_count 0x0001 after cycle 4 and 0x0003 after cycle 12; o_running=1.
2. Pause/resume: start, pause at cycle 6 (prescaler=1), hold 20 cycles, resume -> next tick 3 cycles after resume; count unchanged during the pause.
3. Cascade carry: run from 0x0099 -> next tick gives 0x0100; from 0x0999 -> 0x1000.
4. Wrap vs saturate: ROLLOVER=1 at 0x9999 -> tick gives 0x0000, o_overflow=1, still running. ROLLOVER=0 -> holds 0x9999, o_running=0, start_stop ignored; clear -> 0x0000, IDLE.
5. Lap: RUN at 0x0012, lap -> o_digits frozen at 0x0012 while o_count advances to 0x0015; lap again -> o_digits = 0x0015. Lap in a tick cycle latches the pre-increment value.
6. Priority/reset: clear and start_stop together in PAUSE -> IDLE, 0x0000, not running. Clear in RUN -> ignored. i_rst mid-RUN with lap active -> all outputs zero next cycle.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause controller for a 4-digit BCD stopwatch: prescaled count tick,
// single-cycle carry chain, lap freeze for the display path and sticky overflow.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter bit ROLLOVER = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_stop,
  input  logic        i_lap,
  input  logic        i_clear,
  output logic [15:0] o_digits,
  output logic [15:0] o_count,
  output logic        o_tick,
  output logic        o_running,
  output logic        o_lap_active,
  output logic        o_overflow
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_SAT} state_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic [15:0]   r_count, w_count_next, w_count_inc;
  logic [15:0]   r_lap, w_lap_next;
  logic          r_running, r_lap_active, r_overflow;
  logic          w_lap_active_next, w_overflow_next;
  logic          w_tick, w_terminal, w_clear_ok, w_lap_ok;

  assign w_tick     = (r_state == S_RUN) && (r_presc == P_LAST);
  assign w_terminal = w_tick && (r_count == 16'h9999);
  assign w_clear_ok = i_clear && (r_state != S_RUN);
  assign w_lap_ok   = i_lap && !w_clear_ok && ((r_state == S_RUN) || (r_state == S_PAUSE));

  // All four digit carries resolve in the same cycle; 9999 rolls to 0000.
  always_comb begin
    logic w_carry;
    w_count_inc = r_count;
    w_carry     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (w_carry)
        w_count_inc[4*k +: 4] = (r_count[4*k +: 4] == 4'd9) ? 4'd0 : r_count[4*k +: 4] + 4'd1;
      w_carry = w_carry && (r_count[4*k +: 4] == 4'd9);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start_stop) w_state_next = S_RUN;
      S_RUN: begin
        if (w_terminal && !ROLLOVER) w_state_next = S_SAT;
        else if (i_start_stop)       w_state_next = S_PAUSE;
      end
      S_PAUSE: if (i_start_stop) w_state_next = S_RUN;
      default: w_state_next = r_state;
    endcase
    if (w_clear_ok) w_state_next = S_IDLE;
  end

  always_comb begin
    w_presc_next      = r_presc;
    w_count_next      = r_count;
    w_lap_next        = r_lap;
    w_lap_active_next = r_lap_active;
    w_overflow_next   = r_overflow || (w_terminal && ROLLOVER);
    // The pausing cycle does not advance the prescaler, so resume picks up
    // exactly where the pause press found it.
    if (w_clear_ok || (r_state == S_IDLE)) begin
      w_presc_next = '0;
    end else if (r_state == S_RUN) begin
      if (w_tick)             w_presc_next = '0;
      else if (!i_start_stop) w_presc_next = r_presc + 1'b1;
    end
    if (w_clear_ok) begin
      w_count_next      = '0;
      w_lap_next        = '0;
      w_lap_active_next = 1'b0;
      w_overflow_next   = 1'b0;
    end else begin
      if (w_tick && !(w_terminal && !ROLLOVER)) w_count_next = w_count_inc;
      if (w_lap_ok) begin
        w_lap_active_next = !r_lap_active;
        if (!r_lap_active) w_lap_next = r_count;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_count      <= '0;
      r_lap        <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_count      <= w_count_next;
      r_lap        <= w_lap_next;
      r_running    <= (w_state_next == S_RUN);
      r_lap_active <= w_lap_active_next;
      r_overflow   <= w_overflow_next;
    end
  end

  assign o_count      = r_count;
  assign o_digits     = r_lap_active ? r_lap : r_count;
  assign o_tick       = w_tick;
  assign o_running    = r_running;
  assign o_lap_active = r_lap_active;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: TICK_DIV=4 instance for timing, carry, lap and
// priority; two TICK_DIV=2 instances run alongside for wrap and saturation.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_m, start_m, lap_m, clear_m;
  logic [15:0] digits_m, count_m;
  logic        tick_m, running_m, lap_act_m, ovf_m;

  logic        rst_x, start_w, start_s, lap_s, clear_s;
  logic        zero_w;
  logic [15:0] digits_w, count_w, digits_s, count_s;
  logic        tick_w, running_w, lap_act_w, ovf_w;
  logic        tick_s, running_s, lap_act_s, ovf_s;

  stopwatch_ctrl #(.TICK_DIV(4), .ROLLOVER(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst_m), .i_start_stop(start_m), .i_lap(lap_m), .i_clear(clear_m),
    .o_digits(digits_m), .o_count(count_m), .o_tick(tick_m), .o_running(running_m),
    .o_lap_active(lap_act_m), .o_overflow(ovf_m));

  stopwatch_ctrl #(.TICK_DIV(2), .ROLLOVER(1'b1)) u_wrap (
    .i_clk(clk), .i_rst(rst_x), .i_start_stop(start_w), .i_lap(zero_w), .i_clear(zero_w),
    .o_digits(digits_w), .o_count(count_w), .o_tick(tick_w), .o_running(running_w),
    .o_lap_active(lap_act_w), .o_overflow(ovf_w));

  stopwatch_ctrl #(.TICK_DIV(2), .ROLLOVER(1'b0)) u_sat (
    .i_clk(clk), .i_rst(rst_x), .i_start_stop(start_s), .i_lap(lap_s), .i_clear(clear_s),
    .o_digits(digits_s), .o_count(count_s), .o_tick(tick_s), .o_running(running_s),
    .o_lap_active(lap_act_s), .o_overflow(ovf_s));

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          wrap_done = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_m = 1'b1;
    step();
    rst_m = 1'b0;
  endtask

  task automatic pulse_start(output int t0);
    start_m = 1'b1;
    t0 = cyc;
    step();
    start_m = 1'b0;
  endtask

  task automatic wait_tick(input int budget, input string tag);
    int n = 0;
    while (tick_m !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (tick_m !== 1'b1) check(tag, 16'(tick_m), 16'h0001);
  endtask

  task automatic run_to(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (count_m !== target && n < budget) begin
      step();
      n++;
    end
    check(tag, count_m, target);
  endtask

  // Main instance
  initial begin : main_seq
    int t0, tr, ticks, n;
    rst_m = 1'b1; start_m = 1'b0; lap_m = 1'b0; clear_m = 1'b0;
    step();
    check("rst_count", count_m, 16'h0000);
    check("rst_digits", digits_m, 16'h0000);
    check("rst_flags", {12'h000, tick_m, running_m, lap_act_m, ovf_m}, 16'h0000);
    rst_m = 1'b0;

    // start: ticks at cycles 4, 8, 12 with the count following each one
    pulse_start(t0);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(16'(4 * i));
      exp_q.push_back(16'(i));
    end
    for (int i = 1; i <= 3; i++) begin
      wait_tick(10, "t1_tick_timeout");
      check("t1_tick_cycle", 16'(cyc - t0), exp_q.pop_front());
      step();
      check("t1_count", count_m, exp_q.pop_front());
    end
    check("t1_running", 16'(running_m), 16'h0001);

    // pause at cycle 6 with prescaler=1, resume lands a tick 3 cycles later
    do_reset();
    pulse_start(t0);
    while (cyc < t0 + 6) step();
    pulse_start(tr);
    check("t2_count_at_pause", count_m, 16'h0001);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ticks += int'(tick_m);
    end
    check("t2_pause_ticks", 16'(ticks), 16'h0000);
    check("t2_pause_count", count_m, 16'h0001);
    check("t2_pause_running", 16'(running_m), 16'h0000);
    exp_q.push_back(16'd3);
    exp_q.push_back(16'h0002);
    pulse_start(tr);
    wait_tick(10, "t2_tick_timeout");
    check("t2_resume_latency", 16'(cyc - tr), exp_q.pop_front());
    step();
    check("t2_resume_count", count_m, exp_q.pop_front());

    // cascade carries
    do_reset();
    pulse_start(t0);
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h1000);
    run_to(16'h0009, 100, "t3_reach_0009");
    wait_tick(8, "t3_tick_timeout");
    step();
    check("t3_carry_0010", count_m, exp_q.pop_front());
    run_to(16'h0099, 400, "t3_reach_0099");
    wait_tick(8, "t3_tick_timeout");
    step();
    check("t3_carry_0100", count_m, exp_q.pop_front());
    run_to(16'h0999, 4000, "t3_reach_0999");
    wait_tick(8, "t3_tick_timeout");
    step();
    check("t3_carry_1000", count_m, exp_q.pop_front());

    // lap freeze, release, and a press that coincides with a tick
    do_reset();
    pulse_start(t0);
    run_to(16'h0012, 100, "t5_reach_0012");
    lap_m = 1'b1; step(); lap_m = 1'b0;
    check("t5_lap_active", 16'(lap_act_m), 16'h0001);
    check("t5_digits_frozen", digits_m, 16'h0012);
    run_to(16'h0015, 20, "t5_reach_0015");
    check("t5_still_frozen", digits_m, 16'h0012);
    lap_m = 1'b1; step(); lap_m = 1'b0;
    check("t5_lap_release", 16'(lap_act_m), 16'h0000);
    check("t5_digits_live", digits_m, 16'h0015);
    exp_q.push_back(16'h0015);
    exp_q.push_back(16'h0016);
    wait_tick(8, "t5_tick_timeout");
    lap_m = 1'b1; step(); lap_m = 1'b0;
    check("t5_lap_pre_inc", digits_m, exp_q.pop_front());
    check("t5_count_post_tick", count_m, exp_q.pop_front());

    // clear in RUN is ignored; reset mid-run with lap active zeroes everything
    clear_m = 1'b1; step(); clear_m = 1'b0;
    check("t6_clear_run_count", count_m, 16'h0016);
    check("t6_clear_run_flags", {14'h0000, running_m, lap_act_m}, 16'h0003);
    do_reset();
    check("t6_rst_count", count_m, 16'h0000);
    check("t6_rst_digits", digits_m, 16'h0000);
    check("t6_rst_flags", {12'h000, tick_m, running_m, lap_act_m, ovf_m}, 16'h0000);

    // start_stop with lap in RUN: both act
    pulse_start(t0);
    wait_tick(8, "t6_tick_timeout");
    step();
    start_m = 1'b1; lap_m = 1'b1; step(); start_m = 1'b0; lap_m = 1'b0;
    check("t6_pause_lap_flags", {14'h0000, running_m, lap_act_m}, 16'h0001);
    check("t6_pause_lap_digits", digits_m, 16'h0001);
    // clear beats start_stop and lap in PAUSE
    clear_m = 1'b1; start_m = 1'b1; lap_m = 1'b1;
    step();
    clear_m = 1'b0; start_m = 1'b0; lap_m = 1'b0;
    check("t6_prio_count", count_m, 16'h0000);
    check("t6_prio_digits", digits_m, 16'h0000);
    check("t6_prio_flags", {14'h0000, running_m, lap_act_m}, 16'h0000);
    for (int i = 0; i < 6; i++) step();
    check("t6_stays_idle", {15'h0000, running_m}, 16'h0000);
    check("t6_idle_count", count_m, 16'h0000);

    n = 0;
    while (!wrap_done && n < 30000) begin
      step();
      n++;
    end
    check("wrap_sat_done", 16'(wrap_done), 16'h0001);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Wrap and saturate instances, started together so they hit 9999 on the same tick
  initial begin : wrap_seq
    int n, ticks;
    rst_x = 1'b1; start_w = 1'b0; start_s = 1'b0; lap_s = 1'b0; clear_s = 1'b0; zero_w = 1'b0;
    @(negedge clk);
    rst_x = 1'b0;
    start_w = 1'b1; start_s = 1'b1;
    @(negedge clk);
    start_w = 1'b0; start_s = 1'b0;
    n = 0;
    while (count_w !== 16'h9999 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    check("t4_wrap_reach", count_w, 16'h9999);
    check("t4_sat_reach", count_s, 16'h9999);
    check("t4_ovf_before", {14'h0000, ovf_w, ovf_s}, 16'h0000);
    n = 0;
    while (tick_w !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("t4_terminal_tick", {14'h0000, tick_w, tick_s}, 16'h0003);
    @(negedge clk);
    check("t4_wrap_count", count_w, 16'h0000);
    check("t4_wrap_flags", {14'h0000, ovf_w, running_w}, 16'h0003);
    check("t4_sat_count", count_s, 16'h9999);
    check("t4_sat_flags", {14'h0000, ovf_s, running_s}, 16'h0000);
    n = 0;
    while (tick_w !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t4_wrap_next", count_w, 16'h0001);
    check("t4_ovf_sticky", 16'(ovf_w), 16'h0001);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ticks += int'(tick_s);
    end
    check("t4_sat_no_ticks", 16'(ticks), 16'h0000);
    start_s = 1'b1; lap_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0; lap_s = 1'b0;
    @(negedge clk);
    check("t4_sat_ignores", {14'h0000, running_s, lap_act_s}, 16'h0000);
    check("t4_sat_still_9999", count_s, 16'h9999);
    clear_s = 1'b1;
    @(negedge clk);
    clear_s = 1'b0;
    check("t4_sat_clear_count", count_s, 16'h0000);
    check("t4_sat_clear_flags", {14'h0000, running_s, ovf_s}, 16'h0000);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check("t4_sat_restart", 16'(running_s), 16'h0001);
    wrap_done = 1'b1;
  end

endmodule
